// File: rtl/headgen_seq_ctrl.sv
// Header-generation sequencer: walks per-VLAN microcode in the stage RAMs and streams header bytes.
// Optional back-to-back request acceptance on the last beat is enabled by defining HEADGEN_SEQ_B2B_EN.
module headgen_seq_ctrl #(
  parameter int VLAN_W  = 4,
  parameter int OFF_W   = 9,
  parameter int LEN_W   = 16,
  parameter int MAX_HDR = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [VLAN_W-1:0]         req_vlan,
  input  logic [LEN_W-1:0]          req_body_len,
  output logic [VLAN_W+OFF_W-1:0]   pipe_addr,
  output logic [LEN_W-1:0]          pipe_len,
  output logic                      pipe_en,
  input  logic [8:0]                pipe_q,
  output logic                      hdr_valid,
  input  logic                      hdr_ready,
  output logic                      hdr_last,
  output logic [OFF_W-1:0]          hdr_cnt,
  output logic                      err_overrun,
  output logic                      busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PRIME  = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;

  localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(MAX_HDR - 1);
  localparam logic [OFF_W-1:0] OFF_ONE  = OFF_W'(1);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt;
  logic [VLAN_W-1:0] vlan_r;
  logic [OFF_W-1:0]  off_r;
  logic [LEN_W-1:0]  len_r;
  logic [OFF_W-1:0]  cnt_r;
  logic              accept;
  logic              unused_byte;

  // The byte lane goes straight to the assembler; only the last flag matters here.
  assign unused_byte = ^pipe_q[7:0];

  assign pipe_addr = {vlan_r, off_r};
  assign pipe_len  = len_r;
  assign hdr_cnt   = cnt_r;

  // Next-state and handshake decode; the stage enable doubles as the stream stall.
  always_comb begin
    state_nxt   = state_r;
    accept      = 1'b0;
    req_ready   = 1'b0;
    pipe_en     = 1'b0;
    hdr_valid   = 1'b0;
    hdr_last    = 1'b0;
    err_overrun = 1'b0;
    busy        = 1'b1;
    case (state_r)
      IDLE: begin
        busy      = 1'b0;
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = PRIME;
        end else begin
          state_nxt = IDLE;
        end
      end
      PRIME: begin
        pipe_en   = 1'b1;
        state_nxt = STREAM;
      end
      STREAM: begin
        hdr_valid = 1'b1;
        hdr_last  = pipe_q[8] | (cnt_r == CNT_LAST);
        pipe_en   = hdr_ready & ~hdr_last;
        if (hdr_ready && hdr_last) begin
          err_overrun = ~pipe_q[8];
`ifdef HEADGEN_SEQ_B2B_EN
          req_ready = 1'b1;
          if (req_valid) begin
            accept    = 1'b1;
            state_nxt = PRIME;
          end else begin
            state_nxt = IDLE;
          end
`else
          state_nxt = IDLE;
`endif
        end else begin
          state_nxt = STREAM;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, request latch and address/count advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      vlan_r  <= '0;
      off_r   <= '0;
      len_r   <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt;
      if (accept) begin
        vlan_r <= req_vlan;
        off_r  <= '0;
        len_r  <= req_body_len;
        cnt_r  <= '0;
      end else if (pipe_en) begin
        off_r <= off_r + OFF_ONE;
        // PRIME fetches word 0 without advancing the byte index.
        if (state_r == STREAM) begin
          cnt_r <= cnt_r + OFF_ONE;
        end else begin
          cnt_r <= cnt_r;
        end
      end else begin
        off_r <= off_r;
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_headgen_seq_ctrl.sv
// Self-checking bench for headgen_seq_ctrl: microcode RAM model, scoreboard queues, request table.
module tb_headgen_seq_ctrl;

  localparam int VLAN_W  = 4;
  localparam int OFF_W   = 9;
  localparam int LEN_W   = 16;
  localparam int MAX_HDR = 128;
`ifdef HEADGEN_SEQ_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    req_valid;
  logic                    req_ready;
  logic [VLAN_W-1:0]       req_vlan;
  logic [LEN_W-1:0]        req_body_len;
  logic [VLAN_W+OFF_W-1:0] pipe_addr;
  logic [LEN_W-1:0]        pipe_len;
  logic                    pipe_en;
  logic [8:0]              pipe_q;
  logic                    hdr_valid;
  logic                    hdr_ready;
  logic                    hdr_last;
  logic [OFF_W-1:0]        hdr_cnt;
  logic                    err_overrun;
  logic                    busy;

  always #5 clk = ~clk;

  headgen_seq_ctrl #(.VLAN_W(VLAN_W), .OFF_W(OFF_W), .LEN_W(LEN_W), .MAX_HDR(MAX_HDR)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_vlan(req_vlan),
    .req_body_len(req_body_len), .pipe_addr(pipe_addr), .pipe_len(pipe_len), .pipe_en(pipe_en),
    .pipe_q(pipe_q), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_last(hdr_last),
    .hdr_cnt(hdr_cnt), .err_overrun(err_overrun), .busy(busy)
  );

  // Stage RAM model: registered read, held while the enable is low.
  logic [8:0] mem [0:8191];
  logic [8:0] q_model;
  always @(posedge clk or posedge rst) begin
    if (rst) q_model <= 9'h000;
    else if (pipe_en) q_model <= mem[pipe_addr];
  end
  assign pipe_q = q_model;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [8:0] cnt;
    logic       err;
  } beat_t;

  typedef struct {
    logic [3:0]  vlan;
    logic [15:0] len;
    int          stall_at;
    int          stall_n;
    int          exp_beats;
  } vec_t;

  beat_t       beat_q[$];
  logic [12:0] addr_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc_n = 0;
  int   accept_cyc = -100;
  int   end_cyc = -100;
  int   gap_meas = -1;
  int   acc_cnt = 0;
  int   beats_done = 0;
  logic prev_valid = 1'b0;
  logic active = 1'b0;
  logic [15:0] cur_len = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc_n);
  endtask

  // Per-cycle comparison of DUT outputs against the scoreboard.
  task automatic monitor();
    beat_t b;
    logic  hs;
    logic  hs_last;
    hs      = hdr_valid && hdr_ready;
    hs_last = hs && (beat_q.size() > 0) && beat_q[0].last;
    if (pipe_en) begin
      if (addr_q.size() == 0) fail("extra_read");
      else chk("pipe_addr", 32'(pipe_addr), 32'(addr_q.pop_front()));
    end
    if (hdr_valid && !prev_valid) begin
      chk("latency", 32'(cyc_n - accept_cyc), 32'd2);
      gap_meas = cyc_n - end_cyc - 1;
    end
    if (hdr_valid && !hdr_ready && beat_q.size() > 0) begin
      chk("hold_en", 32'(pipe_en), 32'd0);
      chk("hold_data", 32'(pipe_q[7:0]), 32'(beat_q[0].data));
      if (addr_q.size() > 0) chk("hold_addr", 32'(pipe_addr), 32'(addr_q[0]));
    end
    if (hs) begin
      if (beat_q.size() == 0) fail("extra_beat");
      else begin
        b = beat_q.pop_front();
        chk("hdr_byte", 32'(pipe_q[7:0]), 32'(b.data));
        chk("hdr_last", 32'(hdr_last), 32'(b.last));
        chk("hdr_cnt", 32'(hdr_cnt), 32'(b.cnt));
        chk("err_overrun", 32'(err_overrun), 32'(b.err));
        chk("pipe_len", 32'(pipe_len), 32'(cur_len));
        beats_done++;
      end
    end else begin
      chk("err_quiet", 32'(err_overrun), 32'd0);
    end
    if (active) chk("req_ready_busy", 32'(req_ready), hs_last ? 32'(B2B) : 32'd0);
    else chk("req_ready_idle", 32'(req_ready), 32'd1);
    if (hs_last) begin
      active  = 1'b0;
      end_cyc = cyc_n;
    end
    if (req_valid && req_ready) begin
      active     = 1'b1;
      accept_cyc = cyc_n;
      acc_cnt++;
      cur_len    = req_body_len;
    end
    prev_valid = hdr_valid;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  // Reference walk of the microcode for one VLAN: expected beats and read addresses.
  task automatic push_model(input logic [3:0] vlan);
    beat_t      b;
    logic [8:0] w;
    logic [8:0] o;
    for (int off = 0; off < MAX_HDR; off++) begin
      o      = off[8:0];
      w      = mem[{vlan, o}];
      b.data = w[7:0];
      b.last = w[8] || (off == MAX_HDR - 1);
      b.cnt  = o;
      b.err  = b.last && !w[8];
      beat_q.push_back(b);
      addr_q.push_back({vlan, o});
      if (b.last) break;
    end
  endtask

  task automatic wait_accept(input int start);
    for (int i = 0; i < 20 && acc_cnt == start; i++) step();
    if (acc_cnt == start) fail("accept_timeout");
  endtask

  task automatic drain(input int stall_at, input int stall_n, input int bd0);
    int stalled = 0;
    for (int i = 0; i < 400 && beat_q.size() > 0; i++) begin
      hdr_ready = !((beats_done - bd0 == stall_at) && (stalled < stall_n));
      if (!hdr_ready) stalled++;
      step();
    end
    hdr_ready = 1'b1;
    if (beat_q.size() > 0) begin
      fail("beat_timeout");
      beat_q.delete();
    end
    chk("reads_left", 32'(addr_q.size()), 32'd0);
    addr_q.delete();
  endtask

  vec_t vecs[4];

  initial begin
    int bd0;
    int start;
    vecs[0] = '{vlan: 4'd3, len: 16'h0040, stall_at: -1, stall_n: 0, exp_beats: 3};
    vecs[1] = '{vlan: 4'd3, len: 16'h0040, stall_at: 1,  stall_n: 3, exp_beats: 3};
    vecs[2] = '{vlan: 4'd5, len: 16'h1234, stall_at: -1, stall_n: 0, exp_beats: 128};
    vecs[3] = '{vlan: 4'd6, len: 16'hBEEF, stall_at: 2,  stall_n: 2, exp_beats: 5};

    for (int i = 0; i < 8192; i++) mem[i] = 9'h000;
    mem[13'h600] = 9'h0AA; mem[13'h601] = 9'h0BB; mem[13'h602] = 9'h1CC;
    for (int k = 0; k < 128; k++) mem[13'hA00 + k] = {1'b0, 8'(k ^ 8'h5A)};
    mem[13'hC00] = 9'h001; mem[13'hC01] = 9'h002; mem[13'hC02] = 9'h003;
    mem[13'hC03] = 9'h004; mem[13'hC04] = 9'h105;
    mem[13'hE00] = 9'h1FF;
    mem[13'h200] = 9'h011; mem[13'h201] = 9'h112;
    mem[13'h400] = 9'h021; mem[13'h401] = 9'h122;

    rst = 1'b1; req_valid = 1'b0; req_vlan = 4'd0; req_body_len = 16'h0000; hdr_ready = 1'b1;
    #12;
    chk("rst_addr", 32'(pipe_addr), 32'd0);
    chk("rst_valid", 32'(hdr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Table-driven requests.
    for (int v = 0; v < 4; v++) begin
      push_model(vecs[v].vlan);
      req_vlan = vecs[v].vlan; req_body_len = vecs[v].len; req_valid = 1'b1;
      start = acc_cnt;
      bd0 = beats_done;
      wait_accept(start);
      req_valid = 1'b0;
      drain(vecs[v].stall_at, vecs[v].stall_n, bd0);
      chk("beats", 32'(beats_done - bd0), 32'(vecs[v].exp_beats));
      step(); step();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_valid", 32'(hdr_valid), 32'd0);
    end

    // Reset asserted between edges at beat 3 of a long header.
    push_model(4'd5);
    req_vlan = 4'd5; req_body_len = 16'h7777; req_valid = 1'b1;
    start = acc_cnt;
    bd0 = beats_done;
    wait_accept(start);
    req_valid = 1'b0;
    for (int i = 0; i < 20 && (beats_done - bd0) < 3; i++) step();
    chk("pre_rst_beats", 32'(beats_done - bd0), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(hdr_valid), 32'd0);
    chk("mid_rst_en", 32'(pipe_en), 32'd0);
    chk("mid_rst_addr", 32'(pipe_addr), 32'd0);
    chk("mid_rst_len", 32'(pipe_len), 32'd0);
    chk("mid_rst_cnt", 32'(hdr_cnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    beat_q.delete(); addr_q.delete(); active = 1'b0; prev_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("post_rst_valid", 32'(hdr_valid), 32'd0);

    // One-beat header with a second request held through its STREAM cycle.
    push_model(4'd7);
    push_model(4'd3);
    req_vlan = 4'd7; req_body_len = 16'h0011; req_valid = 1'b1;
    start = acc_cnt;
    wait_accept(start);
    req_vlan = 4'd3; req_body_len = 16'h0040;
    wait_accept(start + 1);
    req_valid = 1'b0;
    chk("held_accept", 32'(accept_cyc - end_cyc), B2B ? 32'd0 : 32'd1);
    drain(-1, 0, beats_done);

    // Two queued two-beat headers: gap between them.
    step();
    push_model(4'd1);
    push_model(4'd2);
    req_vlan = 4'd1; req_body_len = 16'h0101; req_valid = 1'b1;
    start = acc_cnt;
    wait_accept(start);
    req_vlan = 4'd2; req_body_len = 16'h0202;
    wait_accept(start + 1);
    req_valid = 1'b0;
    drain(-1, 0, beats_done);
    chk("gap", 32'(gap_meas), B2B ? 32'd1 : 32'd2);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
